// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Word-organised data memory behind a valid/ready request channel and a
// valid/ready response channel. Only one request is outstanding at a time:
// a request is accepted in IDLE, waits LATENCY-1 cycles in BUSY, and its
// response is then held in RESP until the initiator takes it. Stores are
// committed and loads are sampled on the edge that enters RESP. Misaligned
// or out-of-range requests complete with resp_err=1 and touch nothing.
//
// Parameters
//   DEPTH      number of 32-bit words of storage (>= 2)
//   LATENCY    cycles from the accepting edge to resp_valid (1..15)
//
// Ports
//   clk          clock, rising-edge
//   reset        asynchronous, active-high; clears control state, not storage
//   req_valid    request presented
//   req_ready    responder is idle and will accept a request this cycle
//   req_write    1 = store, 0 = load
//   req_addr     byte address, word index = req_addr[31:2]
//   req_wdata    store data
//   req_be       store byte enables, bit i covers bits [8i+7:8i]
//   resp_valid   response presented
//   resp_ready   initiator accepts the response
//   resp_rdata   load data (0 for stores and errors)
//   resp_err     request was misaligned or out of range
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Control and captured-request registers
    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Registered outputs
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    // Storage
    logic [31:0] mem [DEPTH];

    // The transaction being completed. With LATENCY=1 the request enters RESP
    // on its own accepting edge, before the capture registers hold it, so in
    // IDLE the live request inputs stand in for the captured copy.
    logic             t_write;
    logic [31:0]      t_addr;
    logic [31:0]      t_wdata;
    logic [3:0]       t_be;
    logic             t_err;
    logic [IDX_W-1:0] t_idx;

    logic             accept;
    logic             enter_resp;
    logic [31:0]      resp_rdata_d;
    logic             resp_err_d;

    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        t_write = write_q;
        t_addr  = addr_q;
        t_wdata = wdata_q;
        t_be    = be_q;
        if (state_q == S_IDLE) begin
            t_write = req_write;
            t_addr  = req_addr;
            t_wdata = req_wdata;
            t_be    = req_be;
        end
    end

    assign t_err  = (t_addr[1:0] != 2'b00) || ({2'b00, t_addr[31:2]} >= 32'(DEPTH));
    assign t_idx  = t_addr[IDX_W+1:2];
    assign accept = (state_q == S_IDLE) && req_valid;

    // Gated by reset: the storage write has no reset term of its own, so a
    // clock edge seen while reset is held must not commit anything.
    assign enter_resp = !reset &&
                        ((accept && (LATENCY == 1)) ||
                         ((state_q == S_BUSY) && (cnt_q == 4'd0)));

    assign resp_rdata_d = (t_err || t_write) ? 32'd0 : mem[t_idx];
    assign resp_err_d   = t_err;

    // NOTE: storage is deliberately left out of reset; it keeps its contents
    // across reset and maps onto plain RAM without a clear path.
    always_ff @(posedge clk) begin
        if (enter_resp && t_write && !t_err) begin
            for (int i = 0; i < 4; i++) begin
                if (t_be[i]) begin
                    mem[t_idx][8*i +: 8] <= t_wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= resp_rdata_d;
                            resp_err_q   <= resp_err_d;
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= resp_rdata_d;
                        resp_err_q   <= resp_err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    // Response registers are only touched here, so they stay
                    // frozen for as long as the initiator stalls.
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders (LATENCY 2, 1 and 15, DEPTH 1024) share one clock and one
// reset; each is exercised in turn while the others sit idle. A word-level
// reference memory covering byte addresses 0x00..0x3C predicts every
// response; expected responses are queued at the accepting edge and a
// separate monitor pops and compares them whenever a response handshake is
// about to happen.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int NI    = 3;
    localparam int LATS [NI] = '{2, 1, 15};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] req_valid;
    logic [NI-1:0] req_ready;
    logic [NI-1:0] req_write;
    logic [NI-1:0] resp_valid;
    logic [NI-1:0] resp_ready;
    logic [NI-1:0] resp_err;
    logic [31:0]   req_addr   [NI];
    logic [31:0]   req_wdata  [NI];
    logic [3:0]    req_be     [NI];
    logic [31:0]   resp_rdata [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (LATS[g])
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    always #5 clk = ~clk;

    // Reference state and scoreboard
    bit [31:0] mdl [16];
    exp_t      exp_q [$];
    exp_t      mon_e;
    int        checks  = 0;
    int        errors  = 0;
    int        cur_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (LATENCY=%0d, t=%0t): got 0x%08h, expected 0x%08h",
                     name, cur_lat, $time, act, exp);
        end
    endtask

    // Behavioural model: a request's outcome from the addressing rules alone.
    function automatic exp_t model_req(input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] be);
        exp_t        e;
        int unsigned widx;
        widx    = a / 4;
        e.err   = (a % 4 != 0) || (widx >= DEPTH);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mdl[widx][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                e.rdata = mdl[widx];
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    // Monitor: a response is consumed on the next rising edge when both
    // valid and ready are high at the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (resp_valid[k] && resp_ready[k]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp (LATENCY=%0d, t=%0t): got rdata 0x%08h err %0b, expected no response",
                             cur_lat, $time, resp_rdata[k], resp_err[k]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata[k], mon_e.rdata);
                    check("resp_err", 32'(resp_err[k]), 32'(mon_e.err));
                end
            end
        end
    end

    // One complete transaction with optional response back-pressure. While
    // the request is outstanding the request inputs carry junk with
    // req_valid held high, which the responder must ignore.
    task automatic do_req(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input int stall);
        exp_t e;
        int   n;
        logic seen;
        @(posedge clk); #1;
        req_valid[k]  = 1'b1;
        req_write[k]  = w;
        req_addr[k]   = a;
        req_wdata[k]  = d;
        req_be[k]     = be;
        resp_ready[k] = 1'b0;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        e = model_req(w, a, d, be);
        exp_q.push_back(e);
        #1;
        req_write[k] = 1'($urandom);
        req_addr[k]  = rand_addr();
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LATS[k] + 4) begin
            @(negedge clk);
            n++;
            seen = resp_valid[k];
            if (!seen) check("req_ready_busy", 32'(req_ready[k]), 32'd0);
        end
        check("resp_latency", n, LATS[k]);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk);
            check("hold_valid", 32'(resp_valid[k]), 32'd1);
            check("hold_rdata", resp_rdata[k], e.rdata);
            check("hold_err", 32'(resp_err[k]), 32'(e.err));
            check("hold_req_ready", 32'(req_ready[k]), 32'd0);
        end
        @(posedge clk); #1;
        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        @(negedge clk);
        check("req_ready_after_hs", 32'(req_ready[k]), 32'd1);
        check("resp_valid_after_hs", 32'(resp_valid[k]), 32'd0);
        check("scoreboard_popped", exp_q.size(), 0);
    endtask

    task automatic sweep(input int k);
        for (int w = 0; w < 16; w++) do_req(k, 1'b0, 32'(w * 4), 32'd0, 4'd0, $urandom_range(0, 2));
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[k]), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata[k], 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err[k]), 32'd0);
    endtask

    // Store accepted, then reset asserted between edges while in BUSY; the
    // store must vanish and the outputs must drop without a clock edge.
    task automatic reset_in_busy(input int k);
        @(posedge clk); #1;
        req_valid[k]  = 1'b1;
        req_write[k]  = 1'b1;
        req_addr[k]   = 32'h20;
        req_wdata[k]  = 32'h12345678;
        req_be[k]     = 4'hF;
        resp_ready[k] = 1'b0;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        @(negedge clk);
        check("busy_before_reset", 32'(req_ready[k]), 32'd0);
        reset = 1'b1;
        #1;
        check_idle_outputs(k, "reset_busy");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    // Load held in RESP, then reset asserted between edges.
    task automatic reset_in_resp(input int k);
        int   n;
        logic seen;
        @(posedge clk); #1;
        req_valid[k]  = 1'b1;
        req_write[k]  = 1'b0;
        req_addr[k]   = rand_addr();
        resp_ready[k] = 1'b0;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LATS[k] + 4) begin
            @(negedge clk);
            n++;
            seen = resp_valid[k];
        end
        check("resp_before_reset", 32'(seen), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs(k, "reset_resp");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    // Loads issued with req_valid and resp_ready held high: acceptances must
    // be exactly LATENCY+1 cycles apart.
    task automatic back_to_back(input int k, input int nreq);
        int acc;
        int cyc;
        int last;
        acc  = 0;
        cyc  = 0;
        last = -1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b1;
        req_valid[k]  = 1'b1;
        req_write[k]  = 1'b0;
        req_addr[k]   = rand_addr();
        while (acc < nreq && cyc < nreq * (LATS[k] + 1) + 20) begin
            @(negedge clk);
            cyc++;
            if (req_ready[k]) begin
                exp_q.push_back(model_req(1'b0, req_addr[k], 32'd0, 4'd0));
                if (last >= 0) check("b2b_period", cyc - last, LATS[k] + 1);
                last = cyc;
                acc++;
                @(posedge clk); #1;
                req_addr[k] = rand_addr();
                if (acc == nreq) req_valid[k] = 1'b0;
            end
        end
        check("b2b_accepted", acc, nreq);
        req_valid[k] = 1'b0;
        repeat (LATS[k] + 3) @(posedge clk);
        #1;
        resp_ready[k] = 1'b0;
        @(negedge clk);
        check("b2b_drained", exp_q.size(), 0);
    endtask

    task automatic run_instance(input int k);
        int          op;
        int          st;
        logic [31:0] a;
        cur_lat = LATS[k];
        for (int w = 0; w < 16; w++) do_req(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

        // Full store then load; then a single-lane store merged into it.
        do_req(k, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_req(k, 1'b0, 32'h10, 32'd0, 4'd0, 0);
        do_req(k, 1'b1, 32'h10, 32'h00000011, 4'b0001, 0);
        do_req(k, 1'b0, 32'h10, 32'd0, 4'd0, 0);

        // Misaligned, out of range, and an out-of-range store whose low index
        // bits alias word 0.
        do_req(k, 1'b0, 32'h13, 32'd0, 4'd0, 0);
        do_req(k, 1'b0, 32'h1000, 32'd0, 4'd0, 0);
        do_req(k, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
        do_req(k, 1'b1, 32'h22, 32'hA5A5A5A5, 4'hF, 1);
        sweep(k);

        // Long stall, and a store with no lanes enabled.
        do_req(k, 1'b0, 32'h10, 32'd0, 4'd0, 5);
        do_req(k, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 0);
        do_req(k, 1'b0, 32'h14, 32'd0, 4'd0, 0);

        if (LATS[k] >= 2) reset_in_busy(k);
        reset_in_resp(k);
        do_req(k, 1'b0, 32'h20, 32'd0, 4'd0, 0);

        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 5));
            st = int'($urandom_range(0, 3));
            a  = rand_addr();
            case (op)
                0, 1:    do_req(k, 1'b1, a, $urandom, 4'($urandom), st);
                2, 3:    do_req(k, 1'b0, a, $urandom, 4'($urandom), st);
                4:       do_req(k, 1'($urandom), a | 32'($urandom_range(1, 3)), $urandom, 4'hF, st);
                default: do_req(k, 1'($urandom), $urandom | 32'h0000_1000, $urandom, 4'($urandom), st);
            endcase
        end

        back_to_back(k, 6);
        sweep(k);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = 32'd0;
            req_wdata[k]  = 32'd0;
            req_be[k]     = 4'd0;
            resp_ready[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            cur_lat = LATS[k];
            check_idle_outputs(k, "por");
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < NI; k++) run_instance(k);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
